// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial add/subtract controller.
// master drives the request side, slave is the serial_add_ctrl instance.
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, op, a, b,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, WIDTH cycles per op.
// Subtraction is a + ~b + 1, with the +1 injected as the initial carry.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   serial_add_ctrl_if.slave  bus
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             last_bit;
   logic             ha1_s, ha1_c;
   logic             ha2_s, ha2_c;
   logic             c_next;
   logic [WIDTH-1:0] res_nxt;
   logic             busy_c, done_c;

   // Full adder built as two cascaded half adders
   always_comb begin
      ha1_s  = a_sh[0] ^ b_sh[0];
      ha1_c  = a_sh[0] & b_sh[0];
      ha2_s  = ha1_s ^ carry;
      ha2_c  = ha1_s & carry;
      c_next = ha1_c | ha2_c;
   end

   // a_sh doubles as the result register: each consumed operand bit frees
   // the LSB while the new result bit enters at the MSB.
   assign res_nxt  = {ha2_s, a_sh[WIDTH-1:1]};
   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            busy_c = 1'b1;
            if (last_bit) begin
               state_d = FIN;
            end
         end
         FIN: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_sh  <= bus.a;
                  b_sh  <= bus.op ? ~bus.b : bus.b;
                  cnt   <= '0;
                  carry <= bus.op;
               end
            end
            RUN: begin
               a_sh  <= res_nxt;
               b_sh  <= b_sh >> 1;
               cnt   <= cnt + CW'(1);
               carry <= c_next;
               if (last_bit) begin
                  sum_q  <= res_nxt;
                  cout_q <= c_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
- REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal range 2..32.
- REQ-002 clk  input  1  single system clock; all state updates on rising edge.
- REQ-003 rst_n  input  1  reset, asynchronous, active-low.
- REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
- REQ-005 op  input  1  operation select: 0 = a+b, 1 = a-b; sampled with start.
- REQ-006 a  input  WIDTH  first operand; sampled with start.
- REQ-007 b  input  WIDTH  second operand; sampled with start.
- REQ-008 busy  output  1  high while an operation is in progress.
- REQ-009 done  output  1  one-cycle pulse when the result becomes valid.
- REQ-010 sum  output  WIDTH  result of the last completed operation.
- REQ-011 cout  output  1  final carry of the last completed operation (for subtraction: 1 = no borrow).

Function
- REQ-012 The block SHALL be a three-state FSM: IDLE, RUN, FIN.
- REQ-013 IDLE: busy=0, done=0; start=1 on a rising edge SHALL latch a, op, and the effective b (b when op=0, ~b when op=1) into internal shift registers, clear the bit counter to 0, set the carry register to op, and move to RUN.
- REQ-014 RUN: each cycle SHALL process exactly one bit, LSB first: bit = a_i XOR b_i XOR c, c_next = (a_i AND b_i) OR (c AND (a_i XOR b_i)), formed as two cascaded half-adder stages plus an OR of their carries.
- REQ-015 RUN: the result bit SHALL shift into the result register from the MSB side, so after WIDTH shifts bit 0 sits at position 0; the counter SHALL increment by 1 per cycle.
- REQ-016 RUN SHALL last exactly WIDTH cycles; on the cycle that processes bit WIDTH-1, the next state SHALL be FIN.
- REQ-017 FIN: lasts exactly one cycle; done=1, busy=0; sum and cout SHALL hold the final values; the next state SHALL be IDLE unconditionally.
- REQ-018 busy SHALL be 1 exactly in RUN (WIDTH cycles per operation).
- REQ-019 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH.
- REQ-020 start while in RUN or FIN SHALL be ignored (no restart, no operand change); the next operation is accepted only from IDLE.
- REQ-021 Changes to a, b, op after acceptance SHALL NOT affect the running operation.
- REQ-022 sum and cout SHALL update only at the transition into FIN, and SHALL hold their values through IDLE until the next operation completes; intermediate shift contents SHALL NOT appear on sum.
- REQ-023 All arithmetic is modulo 2^WIDTH; overflow is reported only through cout (no signed overflow flag).

Reset
- REQ-024 When rst_n=0, the block SHALL go immediately, without waiting for clk, to IDLE with busy=0, done=0, sum=0, cout=0, counter=0, carry=0.
- REQ-025 Reset during RUN SHALL abort the operation; no done pulse SHALL follow for it.
- REQ-026 After rst_n goes high, the first start SHALL be accepted on the next rising edge.

Verification (WIDTH=4)
- REQ-027 op=0, a=3, b=5, start pulse at edge 0 -> busy high for 4 cycles, done pulse in cycle 5, sum=8, cout=0.
- REQ-028 op=0: a=15,b=1 -> sum=0,cout=1; a=15,b=15 -> sum=14,cout=1; a=0,b=0 -> sum=0,cout=0.
- REQ-029 op=1: a=5,b=3 -> sum=2,cout=1; a=3,b=5 -> sum=14,cout=0; a=7,b=7 -> sum=0,cout=1.
- REQ-030 Start held high continuously, with operands changed in the middle of RUN -> one operation per 6 cycles (IDLE, RUN x4, FIN); each result matches the operands latched at acceptance.
- REQ-031 rst_n pulled low asynchronously in RUN cycle 2 -> busy, done, sum, cout read 0 immediately, no done pulse follows; a new operation started after release completes correctly.
- REQ-032 Exhaustive check: all 512 (a, b, op) combinations -> each sum/cout matches the reference arithmetic, and done occurs exactly once per accepted start.
